// File: rtl/eth_hdr_parser_pkg.sv
// Shared types and header layout constants for the Ethernet/IPv4/L4 header parser.
package eth_hdr_parser_pkg;

    localparam int IDX_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        ETH,
        IPV4,
        L4,
        WAIT_END
    } state_t;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_TCP   = 8'd6;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [3:0]  IP_VERSION_4   = 4'd4;

    // Absolute frame offsets (preamble/SFD already stripped).
    localparam logic [IDX_W-1:0] OFF_SRC_MAC  = 11'd6;
    localparam logic [IDX_W-1:0] OFF_ETH_TYPE = 11'd12;
    localparam logic [IDX_W-1:0] OFF_IP       = 11'd14;
    localparam int               IP_MIN_HDR   = 20;
    localparam logic [3:0]       IHL_MIN      = 4'(IP_MIN_HDR / 4);

    // IPv4 field offsets, absolute.
    localparam logic [IDX_W-1:0] OFF_IP_PROTO = OFF_IP + 11'd9;
    localparam logic [IDX_W-1:0] OFF_IP_SRC   = OFF_IP + 11'd12;
    localparam logic [IDX_W-1:0] OFF_IP_DST   = OFF_IP + 11'd16;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
        logic        is_ipv4;
        logic [7:0]  ip_proto;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] l4_src;
        logic [15:0] l4_dst;
        logic        has_l4;
    } hdr_fields_t;

    function automatic logic is_l4_proto(input logic [7:0] proto);
        return (proto == IP_PROTO_TCP) || (proto == IP_PROTO_UDP);
    endfunction

endpackage

// File: rtl/eth_hdr_parser_capture.sv
// Big-endian byte shift register that loads while the byte index lies in [start, start+W/8).
module hdr_shift_capture
    import eth_hdr_parser_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    input  logic [IDX_W-1:0] start,
    input  logic [7:0]       data,
    output logic [W-1:0]     q
);

    localparam int LEN = W / 8;

    logic [IDX_W:0] pos, lo, hi;
    logic           hit;
    logic [W-1:0]   base;

    // One extra bit so start+LEN cannot wrap near the top of the index range.
    assign pos  = {1'b0, idx};
    assign lo   = {1'b0, start};
    assign hi   = lo + (IDX_W + 1)'(LEN);
    assign hit  = en && (pos >= lo) && (pos < hi);
    assign base = clr ? '0 : q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (hit) begin
            q <= W'({base, data});
        end else if (clr) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/eth_hdr_parser.sv
// Streaming Ethernet header parser: extracts MACs, EtherType, IPv4 addresses/protocol and L4 ports.
module eth_hdr_parser
    import eth_hdr_parser_pkg::*;
#(
    parameter int MAX_BYTES = 2047
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        BeginPacket,
    input  logic        dataPacketReady,
    input  logic [7:0]  oPacketData,
    input  logic        oEndPacket,
    output logic        hdr_valid,
    output logic        hdr_err,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] eth_type,
    output logic        is_ipv4,
    output logic [7:0]  ip_proto,
    output logic [31:0] ip_src,
    output logic [31:0] ip_dst,
    output logic [15:0] l4_src,
    output logic [15:0] l4_dst,
    output logic        has_l4
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_BYTES);

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n, cur;
    logic             acc, valid_n, err_n;
    logic             en_eth, en_ip, en_l4;
    logic [IDX_W-1:0] hdr_end, l4_start, l4_last;

    logic [47:0] dst_sh, src_sh;
    logic [15:0] et_sh, l4s_sh, l4d_sh;
    logic [7:0]  vi_sh, proto_sh;
    logic [31:0] ips_sh, ipd_sh;
    logic [15:0] et_word;

    hdr_fields_t shadow, held, fields_out;

    assign acc = dataPacketReady;
    // Index of the byte presented this cycle; BeginPacket marks byte 0.
    assign cur = BeginPacket ? '0 : idx;

    assign en_eth = acc && (BeginPacket || state == ETH);
    assign en_ip  = acc && !BeginPacket && state == IPV4;
    assign en_l4  = acc && !BeginPacket && state == L4;

    assign hdr_end  = OFF_IP - 11'd1 + IDX_W'({vi_sh[3:0], 2'b00});
    assign l4_start = hdr_end + 11'd1;
    assign l4_last  = hdr_end + 11'd4;
    assign et_word  = {et_sh[7:0], oPacketData};

    hdr_shift_capture #(.W(48)) u_dst (.clk(clk), .reset(reset), .clr(BeginPacket), .en(en_eth),
        .idx(cur), .start(11'd0), .data(oPacketData), .q(dst_sh));
    hdr_shift_capture #(.W(48)) u_src (.clk(clk), .reset(reset), .clr(BeginPacket), .en(en_eth),
        .idx(cur), .start(OFF_SRC_MAC), .data(oPacketData), .q(src_sh));
    hdr_shift_capture #(.W(16)) u_et (.clk(clk), .reset(reset), .clr(BeginPacket), .en(en_eth),
        .idx(cur), .start(OFF_ETH_TYPE), .data(oPacketData), .q(et_sh));
    hdr_shift_capture #(.W(8)) u_vi (.clk(clk), .reset(reset), .clr(BeginPacket), .en(en_ip),
        .idx(cur), .start(OFF_IP), .data(oPacketData), .q(vi_sh));
    hdr_shift_capture #(.W(8)) u_proto (.clk(clk), .reset(reset), .clr(BeginPacket), .en(en_ip),
        .idx(cur), .start(OFF_IP_PROTO), .data(oPacketData), .q(proto_sh));
    hdr_shift_capture #(.W(32)) u_ips (.clk(clk), .reset(reset), .clr(BeginPacket), .en(en_ip),
        .idx(cur), .start(OFF_IP_SRC), .data(oPacketData), .q(ips_sh));
    hdr_shift_capture #(.W(32)) u_ipd (.clk(clk), .reset(reset), .clr(BeginPacket), .en(en_ip),
        .idx(cur), .start(OFF_IP_DST), .data(oPacketData), .q(ipd_sh));
    hdr_shift_capture #(.W(16)) u_l4s (.clk(clk), .reset(reset), .clr(BeginPacket), .en(en_l4),
        .idx(cur), .start(l4_start), .data(oPacketData), .q(l4s_sh));
    hdr_shift_capture #(.W(16)) u_l4d (.clk(clk), .reset(reset), .clr(BeginPacket), .en(en_l4),
        .idx(cur), .start(l4_start + 11'd2), .data(oPacketData), .q(l4d_sh));

    assign shadow = '{
        dst_mac:  dst_sh,
        src_mac:  src_sh,
        eth_type: et_sh,
        is_ipv4:  (et_sh == ETHERTYPE_IPV4) && (vi_sh[7:4] == IP_VERSION_4),
        ip_proto: proto_sh,
        ip_src:   ips_sh,
        ip_dst:   ipd_sh,
        l4_src:   l4s_sh,
        l4_dst:   l4d_sh,
        has_l4:   (et_sh == ETHERTYPE_IPV4) && (vi_sh[7:4] == IP_VERSION_4) && is_l4_proto(proto_sh)
    };

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        valid_n = 1'b0;
        err_n   = 1'b0;
        idx_n   = idx;

        if (BeginPacket) begin
            idx_n = acc ? IDX_W'(1) : '0;
        end else if (acc && idx != MAX_IDX) begin
            idx_n = idx + 11'd1;
        end

        if (BeginPacket) begin
            // A restart silently drops whatever frame was in flight; oEndPacket is ignored.
            if (acc || state != IDLE) state_n = ETH;
        end else begin
            case (state)
                ETH: begin
                    if (acc && cur == OFF_ETH_TYPE + 11'd1) begin
                        if (et_word != ETHERTYPE_IPV4) begin
                            valid_n = 1'b1;
                            state_n = oEndPacket ? IDLE : WAIT_END;
                        end else if (oEndPacket) begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end else begin
                            state_n = IPV4;
                        end
                    end else if (oEndPacket) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
                IPV4: begin
                    if (acc && cur == OFF_IP &&
                        (oPacketData[7:4] != IP_VERSION_4 || oPacketData[3:0] < IHL_MIN)) begin
                        err_n   = 1'b1;
                        state_n = oEndPacket ? IDLE : WAIT_END;
                    end else if (acc && cur == hdr_end) begin
                        if (!is_l4_proto(proto_sh)) begin
                            valid_n = 1'b1;
                            state_n = oEndPacket ? IDLE : WAIT_END;
                        end else if (oEndPacket) begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end else begin
                            state_n = L4;
                        end
                    end else if (oEndPacket) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
                L4: begin
                    if (acc && cur == l4_last) begin
                        valid_n = 1'b1;
                        state_n = oEndPacket ? IDLE : WAIT_END;
                    end else if (oEndPacket) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
                WAIT_END: begin
                    if (oEndPacket) state_n = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            hdr_valid <= 1'b0;
            hdr_err   <= 1'b0;
            held      <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            hdr_valid <= valid_n;
            hdr_err   <= err_n;
            if (hdr_valid) held <= shadow;
        end
    end

    // Shadows are complete and stable during the hdr_valid cycle; afterwards the held copy is shown.
    assign fields_out = hdr_valid ? shadow : held;

    assign dst_mac  = fields_out.dst_mac;
    assign src_mac  = fields_out.src_mac;
    assign eth_type = fields_out.eth_type;
    assign is_ipv4  = fields_out.is_ipv4;
    assign ip_proto = fields_out.ip_proto;
    assign ip_src   = fields_out.ip_src;
    assign ip_dst   = fields_out.ip_dst;
    assign l4_src   = fields_out.l4_src;
    assign l4_dst   = fields_out.l4_dst;
    assign has_l4   = fields_out.has_l4;

endmodule

// File: tb/tb_eth_hdr_parser.sv
// Directed scoreboard bench for eth_hdr_parser: expected header reports queued at drive time.
module tb_eth_hdr_parser;

    typedef struct packed {
        logic        is_err;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        logic        v4;
        logic [7:0]  proto;
        logic [31:0] ips;
        logic [31:0] ipd;
        logic [15:0] l4s;
        logic [15:0] l4d;
        logic        l4;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        BeginPacket = 1'b0;
    logic        dataPacketReady = 1'b0;
    logic [7:0]  oPacketData = 8'h00;
    logic        oEndPacket = 1'b0;
    logic        hdr_valid, hdr_err, is_ipv4, has_l4;
    logic [47:0] dst_mac, src_mac;
    logic [15:0] eth_type, l4_src, l4_dst;
    logic [7:0]  ip_proto;
    logic [31:0] ip_src, ip_dst;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [31:0] cyc = 0;
    logic [7:0]  frm[$];
    exp_t        sb[$];
    exp_t        e1, e2, e3, eb, ei;
    exp_t        none = '0;

    eth_hdr_parser dut (
        .clk(clk), .reset(reset),
        .BeginPacket(BeginPacket), .dataPacketReady(dataPacketReady),
        .oPacketData(oPacketData), .oEndPacket(oEndPacket),
        .hdr_valid(hdr_valid), .hdr_err(hdr_err),
        .dst_mac(dst_mac), .src_mac(src_mac), .eth_type(eth_type), .is_ipv4(is_ipv4),
        .ip_proto(ip_proto), .ip_src(ip_src), .ip_dst(ip_dst),
        .l4_src(l4_src), .l4_dst(l4_dst), .has_l4(has_l4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input string tag, input exp_t e);
        check({tag, ".dst_mac"},  64'(dst_mac),  64'(e.dst));
        check({tag, ".src_mac"},  64'(src_mac),  64'(e.src));
        check({tag, ".eth_type"}, 64'(eth_type), 64'(e.et));
        check({tag, ".is_ipv4"},  64'(is_ipv4),  64'(e.v4));
        check({tag, ".ip_proto"}, 64'(ip_proto), 64'(e.proto));
        check({tag, ".ip_src"},   64'(ip_src),   64'(e.ips));
        check({tag, ".ip_dst"},   64'(ip_dst),   64'(e.ipd));
        check({tag, ".l4_src"},   64'(l4_src),   64'(e.l4s));
        check({tag, ".l4_dst"},   64'(l4_dst),   64'(e.l4d));
        check({tag, ".has_l4"},   64'(has_l4),   64'(e.l4));
    endtask

    function automatic exp_t mk_exp(input logic [47:0] dst, src, input logic [15:0] et,
                                    input logic v4, input logic [7:0] pr,
                                    input logic [31:0] ips, ipd, input logic [15:0] sp, dp,
                                    input logic l4);
        exp_t e = '0;
        e.dst = dst; e.src = src; e.et = et; e.v4 = v4; e.proto = pr;
        e.ips = ips; e.ipd = ipd; e.l4s = sp; e.l4d = dp; e.l4 = l4;
        return e;
    endfunction

    task automatic mk_frame(input logic [47:0] dst, src, input logic [15:0] et,
                            input logic [3:0] ver, ihl, input logic [7:0] pr,
                            input logic [31:0] ips, ipd, input logic [15:0] sp, dp);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        if (et == 16'h0800) begin
            frm.push_back({ver, ihl});
            for (int i = 1; i <= 8; i++) frm.push_back(8'h00);
            frm.push_back(pr);
            frm.push_back(8'h00);
            frm.push_back(8'h00);
            for (int i = 0; i < 4; i++) frm.push_back(ips[31-8*i -: 8]);
            for (int i = 0; i < 4; i++) frm.push_back(ipd[31-8*i -: 8]);
            for (int i = 5; i < int'(ihl); i++) repeat (4) frm.push_back(8'hA5);
            frm.push_back(sp[15:8]);
            frm.push_back(sp[7:0]);
            frm.push_back(dp[15:8]);
            frm.push_back(dp[7:0]);
        end
        while (frm.size() < 64) frm.push_back(8'(frm.size()));
    endtask

    task automatic drive(input logic bp, rdy, input logic [7:0] d, input logic ep);
        @(posedge clk);
        #1;
        BeginPacket = bp;
        dataPacketReady = rdy;
        oPacketData = d;
        oEndPacket = ep;
    endtask

    // Sends frm[first..last]; queues e one cycle after byte `need`, an error one cycle after `err_at`.
    task automatic send(input int first, last, input bit end_it, gaps,
                        input int need, err_at, input exp_t e);
        exp_t er;
        for (int i = first; i <= last; i++) begin
            if (gaps && i > first) drive(1'b0, 1'b0, 8'hEE, 1'b0);
            drive(i == 0, 1'b1, frm[i], end_it && i == last);
            if (i == need) begin
                e.cyc = cyc + 1;
                sb.push_back(e);
            end
            if (i == err_at) begin
                er = '0;
                er.is_err = 1'b1;
                er.cyc = cyc + 1;
                sb.push_back(er);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset === 1'b1 && (hdr_valid || hdr_err)) begin
            check("valid_err_exclusive", 64'(hdr_valid & hdr_err), 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 64'({hdr_valid, hdr_err}), 64'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind_err", 64'(hdr_err), 64'(e.is_err));
                check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                if (!e.is_err && hdr_valid) check_fields("hdr", e);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset.hdr_valid", 64'(hdr_valid), 64'd0);
        check("reset.hdr_err", 64'(hdr_err), 64'd0);
        check_fields("reset", none);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);

        // IPv4/UDP, IHL=5: report after byte 37.
        e1 = mk_exp(48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b1, 8'd17,
                    32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 1'b1);
        mk_frame(e1.dst, e1.src, 16'h0800, 4'd4, 4'd5, 8'd17, e1.ips, e1.ipd, e1.l4s, e1.l4d);
        send(0, 63, 1'b1, 1'b0, 37, -1, e1);

        // ARP: report after byte 13, IP/L4 fields cleared.
        e2 = mk_exp(48'hFFFFFFFFFFFF, 48'h020304050607, 16'h0806, 1'b0, 8'd0,
                    32'd0, 32'd0, 16'd0, 16'd0, 1'b0);
        mk_frame(e2.dst, e2.src, 16'h0806, 4'd0, 4'd0, 8'd0, 32'd0, 32'd0, 16'd0, 16'd0);
        send(0, 59, 1'b1, 1'b0, 13, -1, e2);

        // IPv4/TCP, IHL=6, ready low every other cycle: ports at 38-41.
        e3 = mk_exp(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h0800, 1'b1, 8'd6,
                    32'hC0A80001, 32'hC0A800FE, 16'hC350, 16'h01BB, 1'b1);
        mk_frame(e3.dst, e3.src, 16'h0800, 4'd4, 4'd6, 8'd6, e3.ips, e3.ipd, e3.l4s, e3.l4d);
        send(0, 63, 1'b1, 1'b1, 41, -1, e3);

        // Frame ends at byte 20: error pulse, previous fields held.
        mk_frame(48'h111111111111, 48'h222222222222, 16'h0800, 4'd4, 4'd5, 8'd17,
                 32'h01020304, 32'h05060708, 16'd7, 16'd9);
        send(0, 20, 1'b1, 1'b0, -1, 20, none);
        repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_fields("hold_after_end_err", e3);

        // Frame A aborted by BeginPacket at its byte 25; only frame B reported.
        mk_frame(48'h333333333333, 48'h444444444444, 16'h0800, 4'd4, 4'd5, 8'd17,
                 32'hDEADBEEF, 32'hCAFEF00D, 16'd1111, 16'd2222);
        send(0, 24, 1'b0, 1'b0, -1, -1, none);
        eb = mk_exp(48'h5555AAAA5555, 48'hAAAA5555AAAA, 16'h0800, 1'b1, 8'd17,
                    32'h0A010101, 32'h0A020202, 16'd5353, 16'd53, 1'b1);
        mk_frame(eb.dst, eb.src, 16'h0800, 4'd4, 4'd5, 8'd17, eb.ips, eb.ipd, eb.l4s, eb.l4d);
        send(0, 63, 1'b1, 1'b0, 37, -1, eb);

        // IPv4/ICMP: no L4, report after byte 33, ports not captured.
        ei = mk_exp(48'h0000000000AB, 48'h0000000000CD, 16'h0800, 1'b1, 8'd1,
                    32'h08080808, 32'h08080404, 16'd0, 16'd0, 1'b0);
        mk_frame(ei.dst, ei.src, 16'h0800, 4'd4, 4'd5, 8'd1, ei.ips, ei.ipd, 16'h1111, 16'h2222);
        send(0, 63, 1'b1, 1'b0, 33, -1, ei);

        // Version 6 under EtherType 0x0800: error at byte 14, rest of frame ignored.
        mk_frame(48'h777777777777, 48'h888888888888, 16'h0800, 4'd6, 4'd5, 8'd17,
                 32'h11111111, 32'h22222222, 16'd3, 16'd4);
        send(0, 63, 1'b1, 1'b0, -1, 14, none);
        @(negedge clk);
        check_fields("hold_after_bad_version", ei);

        // oEndPacket on the last needed byte still reports the header.
        mk_frame(e2.dst, e2.src, 16'h0806, 4'd0, 4'd0, 8'd0, 32'd0, 32'd0, 16'd0, 16'd0);
        send(0, 13, 1'b1, 1'b0, 13, -1, e2);

        // Reset at byte 10: outputs cleared, leftover bytes ignored, next frame parses.
        mk_frame(e1.dst, e1.src, 16'h0800, 4'd4, 4'd5, 8'd17, e1.ips, e1.ipd, e1.l4s, e1.l4d);
        send(0, 9, 1'b0, 1'b0, -1, -1, none);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset.hdr_valid", 64'(hdr_valid), 64'd0);
        check_fields("midreset", none);
        @(posedge clk);
        #1 reset = 1'b1;
        send(10, 40, 1'b1, 1'b0, -1, -1, none);
        send(0, 63, 1'b1, 1'b0, 37, -1, e1);

        repeat (5) drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_hdr_parser.md
ETH_HDR_PARSER -- requirements
Module: eth_hdr_parser

Interface
REQ-001 SHALL have one clock, `clk`; all logic is rising-edge clocked.
REQ-002 SHALL have `reset`, asynchronous and active-low.
REQ-003 Parameter MAX_BYTES, default 2047: the byte counter saturation value.
REQ-004 Inputs (from gmii_rx), one per line:
- BeginPacket  in  1: one-cycle pulse, coincident with the first destination-MAC byte.
- dataPacketReady  in  1: oPacketData is valid this cycle.
- oPacketData  in  8: frame byte, preamble/SFD already stripped.
- oEndPacket  in  1: one-cycle pulse, coincident with the last frame byte.
REQ-005 Outputs, one per line:
- hdr_valid  out  1: one-cycle pulse; all header fields below are valid.
- hdr_err  out  1: one-cycle pulse; frame ended or was malformed before the header completed.
- dst_mac  out  48: destination MAC.
- src_mac  out  48: source MAC.
- eth_type  out  16: EtherType.
- is_ipv4  out  1: eth_type equals 0x0800 and version equals 4.
- ip_proto  out  8: IPv4 protocol field.
- ip_src  out  32: IPv4 source address.
- ip_dst  out  32: IPv4 destination address.
- l4_src  out  16: TCP/UDP source port.
- l4_dst  out  16: TCP/UDP destination port.
- has_l4  out  1: ip_proto is 6 or 17 and the ports were captured.

Function
REQ-006 SHALL use an 11-bit byte index: cleared on BeginPacket, incremented on every byte accepted with dataPacketReady=1, saturating at MAX_BYTES.
REQ-007 SHALL implement the FSM states IDLE, ETH, IPV4, L4, WAIT_END.
- IDLE to ETH on BeginPacket with dataPacketReady=1.
- ETH to IPV4 after byte 13 when EtherType is 0x0800.
- IPV4 to L4 after the last IP-header byte when the protocol is 6 or 17.
- Any state to WAIT_END after hdr_valid or hdr_err.
- WAIT_END to IDLE on oEndPacket.
REQ-008 SHALL assemble multi-byte fields big-endian: bytes 0-5 are dst_mac, bytes 6-11 are src_mac, bytes 12-13 are eth_type.
REQ-009 IPV4 state SHALL use offsets relative to byte 14:
- Byte 0: version in bits [7:4], IHL in bits [3:0].
- Byte 9: protocol.
- Bytes 12-15: source address.
- Bytes 16-19: destination address.
REQ-010 L4 ports SHALL be captured at offset 14+4*IHL: source port at +0..1, destination port at +2..3.
REQ-011 hdr_valid SHALL pulse exactly once per frame, on the cycle after the last needed byte is accepted:
- Non-IPv4: after byte 13.
- IPv4 without L4: after byte 33+4*(IHL-5).
- IPv4 with L4: after the 4th port byte.
REQ-012 Output fields SHALL hold their values from hdr_valid until the next hdr_valid; they SHALL NOT change during capture of the next frame.
- Implementation: assemble into shadow registers, copy to the outputs on the hdr_valid cycle.
REQ-013 Cycles with dataPacketReady=0 SHALL neither advance the index nor change state.
REQ-014 hdr_err SHALL pulse, and the FSM go to IDLE, in either case:
- oEndPacket arrives before hdr_valid.
- Version is not 4, or IHL is less than 5, while eth_type is 0x0800.
REQ-015 On a malformed header (version/IHL error) the FSM SHALL go to WAIT_END rather than IDLE.
REQ-016 hdr_valid and hdr_err SHALL never be asserted in the same cycle.
REQ-017 A BeginPacket in any state other than IDLE SHALL abort the current frame and restart in ETH with index 0.
- The aborted frame produces no hdr_valid and no hdr_err.
REQ-018 If oEndPacket coincides with the last needed header byte, hdr_valid SHALL pulse and the FSM SHALL return to IDLE.
REQ-019 If BeginPacket and oEndPacket occur in the same cycle, BeginPacket SHALL take priority; oEndPacket is ignored.
REQ-020 The block SHALL apply no back-pressure; every byte is consumed.

Reset
REQ-021 While reset=0 the block SHALL hold:
- State IDLE.
- Index 0.
- All outputs and shadow registers 0.
REQ-022 Reset asserted mid-frame SHALL discard the frame.
- After release, the block ignores bytes until the next BeginPacket.

Structure
REQ-023 A shared package SHALL hold:
- The FSM state encoding.
- ETHERTYPE_IPV4 = 16'h0800.
- IP_PROTO_TCP = 6 and IP_PROTO_UDP = 17.
- Header offset constants 6, 12, 14, 20.
REQ-024 A sub-module `hdr_shift_capture` is natural: a byte-enable shift register parameterised by width, loaded when the index is in [start, start+len).
- It is instantiated for each field.

Verification
REQ-025 Bench SHALL cover these directed scenarios:
- IPv4/UDP frame, IHL=5, src 10.0.0.1 to 10.0.0.2, ports 1234 to 80 -> hdr_valid once, one cycle after byte 37; ip_src=0x0A000001, l4_dst=0x0050, has_l4=1.
- ARP frame, EtherType 0x0806 -> hdr_valid one cycle after byte 13; is_ipv4=0, has_l4=0.
- IPv4/TCP, IHL=6, with dataPacketReady=0 on every other cycle -> ports captured at bytes 38-41; hdr_valid after byte 41.
- oEndPacket at byte 20 of an IPv4 frame -> hdr_err pulse, no hdr_valid, previous field values held.
- BeginPacket at byte 25 of frame A, then frame B (IPv4/UDP) -> only frame B's fields are reported.
- reset=0 at byte 10 -> all outputs 0; the next full frame parses correctly.
